// File: rtl/mvm_stream_if.sv
// Stream bus between the MVM stream driver and the MAC array.
// Carries the vector words sent to the MAC and the result words coming back.
interface mvm_stream_if #(
  parameter int DATA_LENGTH = 14
);
  logic [DATA_LENGTH-1:0] input_data;
  logic                   input_valid;
  logic                   input_ready;
  logic [DATA_LENGTH-1:0] output_data;
  logic                   output_valid;
  logic                   output_ready;

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_data, output_valid
  );

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_data, output_valid
  );
endinterface

// File: rtl/mvm_stream_driver.sv
// MVM stream driver: streams the x buffer out to the MAC, collects the
// result words into the y buffer and exposes them on a registered read port.
// Optional build macro MVM_DRV_THROTTLE_EN: result ready toggles every RECV
// cycle so results are accepted on alternate cycles only.
//
// state | meaning
// IDLE  | waiting for start, host may load x buffer
// SEND  | streaming x_buf[0..COL-1] to the MAC
// RECV  | collecting ROW result words into y_buf
// DONE  | results valid, host may reload x buffer or restart
module mvm_stream_driver #(
  parameter int DATA_LENGTH       = 14,
  parameter int MATRIX_ROW_LENGTH = 8,
  parameter int MATRIX_COL_LENGTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_en,
  input  logic [$clog2(MATRIX_COL_LENGTH)-1:0] load_addr,
  input  logic [DATA_LENGTH-1:0]               load_data,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  input  logic [$clog2(MATRIX_ROW_LENGTH)-1:0] rd_addr,
  output logic [DATA_LENGTH-1:0]               rd_data,
  mvm_stream_if.master                         stream
);
  localparam int CW = $clog2(MATRIX_COL_LENGTH);
  localparam int RW = $clog2(MATRIX_ROW_LENGTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state;
  logic [DATA_LENGTH-1:0] x_buf [MATRIX_COL_LENGTH];
  logic [DATA_LENGTH-1:0] y_buf [MATRIX_ROW_LENGTH];
  logic [CW-1:0]          send_idx;
  logic [CW-1:0]          send_nxt;
  logic [RW-1:0]          recv_idx;
  logic                   tx_beat;
  logic                   rx_beat;

  assign send_nxt = send_idx + CW'(1);
  assign tx_beat  = stream.input_valid & stream.input_ready;
  assign rx_beat  = stream.output_valid & stream.output_ready;
  assign busy     = (state == S_SEND) || (state == S_RECV);
  assign done     = (state == S_DONE);

  // Run sequencing, x buffer loading, transmit and receive handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      send_idx            <= '0;
      recv_idx            <= '0;
      stream.input_valid  <= 1'b0;
      stream.input_data   <= '0;
      stream.output_ready <= 1'b0;
      for (int i = 0; i < MATRIX_COL_LENGTH; i++) x_buf[i] <= '0;
      for (int i = 0; i < MATRIX_ROW_LENGTH; i++) y_buf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_en) x_buf[load_addr] <= load_data;
          // start sees the pre-load x_buf[0] if both arrive together
          if (start) begin
            state              <= S_SEND;
            stream.input_valid <= 1'b1;
            stream.input_data  <= x_buf[0];
            send_idx           <= '0;
            recv_idx           <= '0;
          end
        end
        S_SEND: begin
          if (tx_beat) begin
            if (send_idx == CW'(MATRIX_COL_LENGTH - 1)) begin
              stream.input_valid  <= 1'b0;
              stream.input_data   <= '0;
              stream.output_ready <= 1'b1;
              state               <= S_RECV;
            end else begin
              send_idx          <= send_nxt;
              stream.input_data <= x_buf[send_nxt];
            end
          end
        end
        S_RECV: begin
          if (rx_beat) begin
            y_buf[recv_idx] <= stream.output_data;
            recv_idx        <= recv_idx + RW'(1);
          end
          if (rx_beat && (recv_idx == RW'(MATRIX_ROW_LENGTH - 1))) begin
            stream.output_ready <= 1'b0;
            state               <= S_DONE;
          end else begin
`ifdef MVM_DRV_THROTTLE_EN
            stream.output_ready <= ~stream.output_ready;
`else
            stream.output_ready <= 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered y buffer read port, live in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= y_buf[rd_addr];
  end
endmodule

// File: tb/tb_mvm_stream_driver.sv
// Self-checking bench for mvm_stream_driver with queue scoreboards for the
// transmitted vector words and the received result words.
module tb_mvm_stream_driver;
  localparam int DL = 14;
  localparam int N  = 8;
`ifdef MVM_DRV_THROTTLE_EN
  localparam int RECV_CYC = 2 * N - 1;
  localparam bit THR      = 1'b1;
`else
  localparam int RECV_CYC = N;
  localparam bit THR      = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [2:0]    load_addr;
  logic [DL-1:0] load_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [2:0]    rd_addr;
  logic [DL-1:0] rd_data;

  mvm_stream_if #(.DATA_LENGTH(DL)) bus ();

  mvm_stream_driver #(
    .DATA_LENGTH(DL), .MATRIX_ROW_LENGTH(N), .MATRIX_COL_LENGTH(N)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .stream(bus)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DL-1:0] exp_x [$];
  logic [DL-1:0] exp_y [$];
  logic [DL-1:0] mx [N];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_x(input int base);
    for (int i = 0; i < N; i++) begin
      mx[i] = DL'(base + i);
      load_en = 1'b1; load_addr = 3'(i); load_data = mx[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic start_run;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (bus.input_valid !== 1'b1 || bus.input_data !== mx[0] || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_run: valid=%b data=%0d busy=%b done=%b, want 1 %0d 1 0",
               bus.input_valid, $signed(bus.input_data), busy, done, $signed(mx[0]));
    end
    for (int i = 0; i < N; i++) exp_x.push_back(mx[i]);
  endtask

  task automatic do_send(input int stall_val, input int stall_n);
    int s = 0;
    int cyc = 0;
    while (exp_x.size() > 0 && cyc < 100) begin
      vectors++;
      if (bus.input_valid !== 1'b1 || bus.input_data !== exp_x[0]) begin
        miscompares++;
        $display("FAIL send_word: valid=%b data=%0d, want 1 %0d",
                 bus.input_valid, $signed(bus.input_data), $signed(exp_x[0]));
      end
      if (exp_x[0] == DL'(stall_val) && s < stall_n) begin
        bus.input_ready = 1'b0; s++;
      end else begin
        bus.input_ready = 1'b1; void'(exp_x.pop_front());
      end
      tick();
      cyc++;
    end
    bus.input_ready = 1'b0;
    exp_x.delete();
    vectors++;
    if (cyc !== N + stall_n) begin
      miscompares++;
      $display("FAIL send_cycles: got %0d want %0d", cyc, N + stall_n);
    end
    vectors++;
    if (bus.input_valid !== 1'b0 || bus.input_data !== '0 || bus.output_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL send_end: valid=%b data=%0d oready=%b busy=%b, want 0 0 1 1",
               bus.input_valid, $signed(bus.input_data), bus.output_ready, busy);
    end
  endtask

  task automatic do_recv(input int base, input bit poke);
    int k = 0;
    int rc = 0;
    bus.output_valid = 1'b1;
    bus.output_data  = DL'(base);
    while (!done && rc < 100) begin
      vectors++;
      if (bus.output_ready !== (THR ? (rc % 2 == 0) : 1'b1)) begin
        miscompares++;
        $display("FAIL recv_ready: cycle %0d got %b want %b", rc, bus.output_ready,
                 THR ? (rc % 2 == 0) : 1'b1);
      end
      if (poke && rc == 2) begin
        start = 1'b1; load_en = 1'b1; load_addr = 3'd0; load_data = 14'h1555;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      if (bus.output_ready) begin
        exp_y.push_back(bus.output_data);
        k++;
      end
      tick();
      rc++;
      bus.output_data = DL'(base + k);
    end
    start = 1'b0; load_en = 1'b0; bus.output_valid = 1'b0;
    vectors++;
    if (rc !== RECV_CYC) begin
      miscompares++;
      $display("FAIL recv_cycles: got %0d want %0d", rc, RECV_CYC);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.output_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL recv_end: done=%b busy=%b oready=%b, want 1 0 0", done, busy, bus.output_ready);
    end
    for (int a = 0; a < N; a++) begin
      rd_addr = 3'(a);
      tick();
      vectors++;
      if (exp_y.size() == 0) begin
        miscompares++;
        $display("FAIL readback_empty: addr %0d has no expected entry", a);
      end else if (rd_data !== exp_y[0]) begin
        miscompares++;
        $display("FAIL readback: addr %0d got %0d want %0d", a, $signed(rd_data), $signed(exp_y[0]));
      end
      if (exp_y.size() > 0) void'(exp_y.pop_front());
    end
    exp_y.delete();
  endtask

  task automatic check_idle_zero(input string tag);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.input_valid !== 1'b0 ||
        bus.input_data !== '0 || bus.output_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy=%b done=%b valid=%b data=%0d oready=%b, want all 0", tag,
               busy, done, bus.input_valid, $signed(bus.input_data), bus.output_ready);
    end
    for (int a = 0; a < N; a++) begin
      rd_addr = 3'(a);
      tick();
      vectors++;
      if (rd_data !== '0) begin
        miscompares++;
        $display("FAIL %s_rd: addr %0d got %0d want 0", tag, a, $signed(rd_data));
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; rd_addr = '0;
    bus.input_ready = 1'b0; bus.output_valid = 1'b0; bus.output_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_idle_zero("reset_state");
  endtask

  task automatic test_send_stall;
    load_x(1);
    start_run();
    do_send(4, 3);
  endtask

  task automatic test_recv;
    do_recv(-5, 1'b0);
  endtask

  task automatic test_start_ignored;
    load_x(-3);
    start_run();
    do_send(-1, 0);
    do_recv(50, 1'b1);
    start_run();
  endtask

  task automatic test_reset_mid_send;
    bus.input_ready = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (bus.input_data !== mx[3] || bus.input_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_send_word: data=%0d valid=%b want %0d 1",
               $signed(bus.input_data), bus.input_valid, $signed(mx[3]));
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.input_valid !== 1'b0 || busy !== 1'b0 || bus.input_data !== '0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b busy=%b data=%0d want 0 0 0",
               bus.input_valid, busy, $signed(bus.input_data));
    end
    exp_x.delete();
    tick();
    reset = 1'b0;
    bus.output_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.input_valid !== 1'b0 || bus.output_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL no_beat_after_reset: valid=%b oready=%b busy=%b want 0 0 0",
                 bus.input_valid, bus.output_ready, busy);
      end
    end
    bus.output_valid = 1'b0;
    bus.input_ready  = 1'b0;
    check_idle_zero("post_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < N; i++) mx[i] = '0;
    start_run();
    do_send(-1, 0);
    do_recv(-8192, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_stall();
    test_recv();
    test_start_ignored();
    test_reset_mid_send();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
